// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-slot TDM mux/demux pair.
package tdm_pkg;

  localparam int unsigned NUM_SLOTS = 4;
  localparam int unsigned SLOT_W    = 2;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } tdm_state_t;

endpackage

// File: rtl/tdm_demux4_if.sv
// Serial slot stream in, four parallel lanes plus status out.
interface tdm_demux4_if #(
  parameter int unsigned WIDTH = 1
) ();

  logic                      in_valid;
  logic                      in_sync;
  logic [WIDTH-1:0]          in_data;
  logic [WIDTH-1:0]          out0;
  logic [WIDTH-1:0]          out1;
  logic [WIDTH-1:0]          out2;
  logic [WIDTH-1:0]          out3;
  logic                      out_valid;
  logic [tdm_pkg::SLOT_W-1:0] slot;
  logic                      locked;
  logic                      sync_err;

  // Upstream side: drives the stream, observes the lanes.
  modport master (
    output in_valid, in_sync, in_data,
    input  out0, out1, out2, out3, out_valid, slot, locked, sync_err
  );

  // Demux side.
  modport slave (
    input  in_valid, in_sync, in_data,
    output out0, out1, out2, out3, out_valid, slot, locked, sync_err
  );

endinterface

// File: rtl/tdm_slot_ctr.sv
// 2-bit slot counter: sync clear, load-to-1 (frame restart), increment with wrap.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              load1_i,
  input  logic              en_i,
  output logic [SLOT_W-1:0] slot_o
);

  logic [SLOT_W-1:0] slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    if (clr_i) begin
      slot_d = '0;
    end else if (load1_i) begin
      slot_d = SLOT_W'(1);
    end else if (en_i) begin
      slot_d = slot_q + SLOT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: collects slot 0..3 words into shadow regs and
// publishes a whole frame to the lane registers with a one-cycle valid pulse.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  tdm_demux4_if.slave  bus
);

  tdm_state_t        state_q, state_d;
  logic [WIDTH-1:0]  shadow_q [NUM_SLOTS-1];
  logic [WIDTH-1:0]  shadow_d [NUM_SLOTS-1];
  logic [WIDTH-1:0]  out_q    [NUM_SLOTS];
  logic [WIDTH-1:0]  out_d    [NUM_SLOTS];
  logic              out_valid_q, out_valid_d;
  logic              sync_err_q, sync_err_d;

  logic              ctr_load1, ctr_en;
  logic [SLOT_W-1:0] slot;

  tdm_slot_ctr u_slot_ctr (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (1'b0),
    .load1_i (ctr_load1),
    .en_i    (ctr_en),
    .slot_o  (slot)
  );

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    sync_err_d  = 1'b0;
    ctr_load1   = 1'b0;
    ctr_en      = 1'b0;

    unique case (state_q)
      HUNT: begin
        if (bus.in_valid && bus.in_sync) begin
          shadow_d[0] = bus.in_data;
          ctr_load1   = 1'b1;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (bus.in_valid) begin
          if (bus.in_sync && (slot != '0)) begin
            // Misplaced sync: drop the partial frame and restart on this word.
            sync_err_d  = 1'b1;
            shadow_d[0] = bus.in_data;
            ctr_load1   = 1'b1;
          end else if (slot == SLOT_W'(NUM_SLOTS - 1)) begin
            for (int i = 0; i < NUM_SLOTS - 1; i++) begin
              out_d[i] = shadow_q[i];
            end
            out_d[NUM_SLOTS-1] = bus.in_data;
            out_valid_d        = 1'b1;
            ctr_en             = 1'b1;
          end else begin
            for (int i = 0; i < NUM_SLOTS - 1; i++) begin
              if (slot == SLOT_W'(i)) begin
                shadow_d[i] = bus.in_data;
              end
            end
            ctr_en = 1'b1;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      for (int i = 0; i < NUM_SLOTS - 1; i++) begin
        shadow_q[i] <= '0;
      end
      for (int i = 0; i < NUM_SLOTS; i++) begin
        out_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
      shadow_q    <= shadow_d;
      out_q       <= out_d;
    end
  end

  assign bus.out0      = out_q[0];
  assign bus.out1      = out_q[1];
  assign bus.out2      = out_q[2];
  assign bus.out3      = out_q[3];
  assign bus.out_valid = out_valid_q;
  assign bus.sync_err  = sync_err_q;
  assign bus.slot      = slot;
  assign bus.locked    = (state_q == RUN);

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-slot time-division demultiplexer: the receive end of the team's 4:1 mux path. A serial stream of slot-ordered words, where the slot 0 word carries a sync mark, is split into four parallel lane registers. A one-cycle valid pulse is issued when a complete frame has been collected. It sits downstream of the 2-bit-select mux/serializer, so `out0..out3` reproduce `in0..in3` as one coherent frame.

## Interface
Parameters:
- `WIDTH`, default 1: bits per slot word and per output lane.

Ports:
- `clk`, input, 1: single clock; all logic on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: `in_data` holds a slot word this cycle.
- `in_sync`, input, 1: qualifies the current word as slot 0. Ignored unless `in_valid` is high.
- `in_data`, input, `WIDTH`: slot word.
- `out0`, `out1`, `out2`, `out3`, output, `WIDTH` each: lane registers for the last complete frame.
- `out_valid`, output, 1: one-cycle pulse; lanes updated this cycle.
- `slot`, output, 2: index of the next expected slot.
- `locked`, output, 1: high in RUN state.
- `sync_err`, output, 1: one-cycle pulse on a misplaced sync.

## Operation
- States:
  - HUNT: wait for sync.
  - RUN: collecting a frame.
- Reset (sync, active-high) sets: state HUNT, `slot`=0, `out0..3`=0, shadow regs=0, `out_valid`=0, `locked`=0, `sync_err`=0.
- HUNT behaviour:
  - Beats with `in_valid`=1 and `in_sync`=0 are dropped.
  - A beat with `in_valid`=1 and `in_sync`=1 writes `in_data` to shadow[0], sets `slot`=1, and moves to RUN.
- RUN, beat with `in_valid`=1 and `in_sync`=0:
  - Writes `in_data` to shadow[`slot`] and increments `slot` (mod 4).
  - If `slot`==0 here, the word is taken as slot 0 despite the missing sync. Sync is checked only when present.
- RUN, beat with `slot`==3: the frame completes.
  - `out0..out2` ← shadow[0..2].
  - `out3` ← `in_data`.
  - `out_valid` pulses.
  - `slot` wraps to 0.
  - State stays RUN.
- RUN, beat with `in_valid`=1, `in_sync`=1 and `slot`≠0 (misplaced sync):
  - `sync_err` pulses.
  - The partial frame is discarded; `out*` unchanged and no `out_valid`.
  - The beat restarts a frame: shadow[0] ← `in_data`, `slot`=1.
- RUN, beat with `in_valid`=1, `in_sync`=1 and `slot`==0: normal frame start, no error.
- `in_valid`=0: all state holds; no pulses. Gaps of any length between beats are legal.
- Outputs `out0..3` change only on frame completion (or reset). No partial frame is ever visible on them.

## Timing
- Latency: `out0..3` and `out_valid` are registered and appear in the cycle after the clock edge that accepted the slot 3 beat.
- `out_valid` is high for exactly 1 cycle per completed frame.
- Minimum frame period is 4 cycles, giving back-to-back `out_valid` every 4 cycles at full rate.
- `sync_err` appears 1 cycle after the offending beat. It never coincides with `out_valid` from the same beat.
- `slot` and `locked` are registered and reflect beats accepted up to the previous edge.
- Reset mid-frame: the next cycle shows all outputs 0 and state HUNT. The partial frame is lost, and the first post-reset frame requires sync.
- Reset has priority over a simultaneous beat.

## Structure
- Shared package `tdm_pkg` holds:
  - `NUM_SLOTS`=4.
  - `SLOT_W`=2.
  - The state enum `tdm_state_t` {HUNT, RUN}.
  - The same package is used by the mux-side serializer.
- One sub-module is natural: `tdm_slot_ctr`, a 2-bit slot counter with enable, load-to-1 and sync clear, shared with the serializer.
- Shadow registers and lane registers stay in the top module.

## Test plan
- Reset, then feed `in_data` 1,0,0,0 (`WIDTH`=1) with sync on the first beat. Required: `out0..3`=1,0,0,0 and one `out_valid` pulse 1 cycle after the 4th beat; `locked`=1 from the cycle after the first beat.
- Feed 8 back-to-back beats encoding frames {0,1,1,1} and {1,0,1,1}, sync on beats 1 and 5. Required: `out_valid` pulses at beats 4+1 and 8+1; outputs match each frame.
- Send 3 beats of a frame, then sync plus 4 beats {1,1,0,1}. Required: `sync_err` pulse after the 4th beat; no `out_valid` for the truncated frame; then `out`=1,1,0,1 with a single `out_valid`.
- Send beats without sync after reset. Required: `out_valid`=0, `locked`=0, `slot`=0. A later sync beat locks.
- Insert 2-cycle `in_valid`=0 gaps between all beats of frame {0,0,1,0}. Required: identical result, with `out_valid` 1 cycle after the last beat.
- Assert `rst` after 2 beats of a frame. Required: all outputs 0 next cycle, `locked`=0; remaining beats without sync are ignored.
